// File: rtl/time_counter.sv
// Real-time timekeeping core: divides clock to a 1 Hz tick and keeps hh:mm:ss
// in binary, with a validated load port. Optional alarm enabled by `define ALARM_EN.
module time_counter #(
  parameter int unsigned CLK_HZ  = 50000000,
  parameter int unsigned PRESC_W = 26
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic [23:0] load_data,
  output logic [23:0] data_ch,
  output logic        sec_pulse,
  output logic        day_wrap
`ifdef ALARM_EN
  ,
  input  logic        alarm_set,
  input  logic [15:0] alarm_time,
  output logic        alarm_out
`endif
);

  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_HZ - 1);

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [5:0]         sec_q, sec_d;
  logic [5:0]         min_q, min_d;
  logic [4:0]         hr_q, hr_d;
  logic               sec_pulse_q, sec_pulse_d;
  logic               day_wrap_q, day_wrap_d;
  logic               tick;

  assign tick = (presc_q == PRESC_MAX);

  always_comb begin
    // NOTE: every signal gets a default first so no path through this block infers a latch.
    presc_d     = presc_q;
    sec_d       = sec_q;
    min_d       = min_q;
    hr_d        = hr_q;
    sec_pulse_d = 1'b0;
    day_wrap_d  = 1'b0;

    if (load) begin
      // Load beats a coincident tick; out-of-range fields collapse to zero individually.
      presc_d = '0;
      hr_d    = (load_data[23:16] > 8'd23) ? 5'd0 : load_data[20:16];
      min_d   = (load_data[15:8]  > 8'd59) ? 6'd0 : load_data[13:8];
      sec_d   = (load_data[7:0]   > 8'd59) ? 6'd0 : load_data[5:0];
    end else if (tick) begin
      presc_d     = '0;
      sec_pulse_d = 1'b1;
      if (sec_q != 6'd59) begin
        sec_d = sec_q + 6'd1;
      end else begin
        sec_d = 6'd0;
        if (min_q != 6'd59) begin
          min_d = min_q + 6'd1;
        end else begin
          min_d = 6'd0;
          if (hr_q != 5'd23) begin
            hr_d = hr_q + 5'd1;
          end else begin
            hr_d       = 5'd0;
            day_wrap_d = 1'b1;
          end
        end
      end
    end else begin
      presc_d = presc_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      presc_q     <= '0;
      sec_q       <= '0;
      min_q       <= '0;
      hr_q        <= '0;
      sec_pulse_q <= 1'b0;
      day_wrap_q  <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      sec_q       <= sec_d;
      min_q       <= min_d;
      hr_q        <= hr_d;
      sec_pulse_q <= sec_pulse_d;
      day_wrap_q  <= day_wrap_d;
    end
  end

  assign data_ch   = {3'b000, hr_q, 2'b00, min_q, 2'b00, sec_q};
  assign sec_pulse = sec_pulse_q;
  assign day_wrap  = day_wrap_q;

`ifdef ALARM_EN
  logic [15:0] alarm_reg_q, alarm_reg_d;
  logic        armed_q, armed_d;
  logic        alarm_out_q, alarm_out_d;
  logic [5:0]  alarm_cnt_q, alarm_cnt_d;
  logic        advance;
  logic        alarm_hit;

  assign advance   = tick & ~load;
  assign alarm_hit = (sec_d == 6'd0) &&
                     ({3'b000, hr_d} == alarm_reg_q[15:8]) &&
                     ({2'b00, min_d} == alarm_reg_q[7:0]);

  always_comb begin
    alarm_reg_d = alarm_reg_q;
    armed_d     = armed_q;
    alarm_out_d = alarm_out_q;
    alarm_cnt_d = alarm_cnt_q;

    if (alarm_set) begin
      alarm_reg_d = alarm_time;
      armed_d     = 1'b1;
      alarm_out_d = 1'b0;
      alarm_cnt_d = 6'd0;
    end else if (alarm_out_q && advance) begin
      // Sixtieth tick while ringing silences the alarm.
      if (alarm_cnt_q == 6'd59) begin
        alarm_out_d = 1'b0;
        alarm_cnt_d = 6'd0;
      end else begin
        alarm_cnt_d = alarm_cnt_q + 6'd1;
      end
    end else if (armed_q && advance && alarm_hit) begin
      alarm_out_d = 1'b1;
      alarm_cnt_d = 6'd0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      alarm_reg_q <= '0;
      armed_q     <= 1'b0;
      alarm_out_q <= 1'b0;
      alarm_cnt_q <= '0;
    end else begin
      alarm_reg_q <= alarm_reg_d;
      armed_q     <= armed_d;
      alarm_out_q <= alarm_out_d;
      alarm_cnt_q <= alarm_cnt_d;
    end
  end

  assign alarm_out = alarm_out_q;
`endif

endmodule

// File: tb/tb_time_counter.sv
// Self-checking bench for time_counter (CLK_HZ=4): seconds-of-day model checked
// every cycle, plus directed literal expectations.
module tb_time_counter;

  localparam int CLK_HZ  = 4;
  localparam int PRESC_W = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [23:0] load_data = 24'h0;
  logic [23:0] data_ch;
  logic        sec_pulse;
  logic        day_wrap;
`ifdef ALARM_EN
  logic        alarm_set = 1'b0;
  logic [15:0] alarm_time = 16'h0;
  logic        alarm_out;
`endif

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Model: time as seconds since midnight, plus edges elapsed since last load/reset.
  int m_secs  = 0;
  int m_since = 0;
  bit m_pulse = 1'b0;
  bit m_wrap  = 1'b0;

  time_counter #(.CLK_HZ(CLK_HZ), .PRESC_W(PRESC_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .load      (load),
    .load_data (load_data),
    .data_ch   (data_ch),
    .sec_pulse (sec_pulse),
    .day_wrap  (day_wrap)
`ifdef ALARM_EN
    ,
    .alarm_set (alarm_set),
    .alarm_time(alarm_time),
    .alarm_out (alarm_out)
`endif
  );

  always #5 clock = ~clock;

  function automatic logic [23:0] model_word();
    int h, m, s;
    h = m_secs / 3600;
    m = (m_secs % 3600) / 60;
    s = m_secs % 60;
    return {8'(h), 8'(m), 8'(s)};
  endfunction

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_secs  = 0;
    m_since = 0;
    m_pulse = 1'b0;
    m_wrap  = 1'b0;
  endtask

  // One clock edge; model follows the inputs held across it, inputs may change 1 time unit later.
  task automatic step();
    int h, m, s;
    @(posedge clock);
    if (load) begin
      h = int'(load_data[23:16]);
      m = int'(load_data[15:8]);
      s = int'(load_data[7:0]);
      if (h > 23) h = 0;
      if (m > 59) m = 0;
      if (s > 59) s = 0;
      m_secs  = h * 3600 + m * 60 + s;
      m_since = 0;
      m_pulse = 1'b0;
      m_wrap  = 1'b0;
    end else begin
      m_since++;
      if (m_since % CLK_HZ == 0) begin
        m_secs  = (m_secs + 1) % 86400;
        m_pulse = 1'b1;
        m_wrap  = (m_secs == 0);
      end else begin
        m_pulse = 1'b0;
        m_wrap  = 1'b0;
      end
    end
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic load_word(input logic [23:0] w);
    load      = 1'b1;
    load_data = w;
    step();
    load      = 1'b0;
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      check("data_ch", data_ch, model_word());
      check("sec_pulse", {23'b0, sec_pulse}, {23'b0, m_pulse});
      check("day_wrap", {23'b0, day_wrap}, {23'b0, m_wrap});
    end
  end

  initial begin
    #12;
    check("reset_data", data_ch, 24'h000000);
    check("reset_pulse", {23'b0, sec_pulse}, 24'h0);
    check("reset_wrap", {23'b0, day_wrap}, 24'h0);
    model_reset();
    reset  = 1'b0;
    chk_en = 1'b1;

    // Free running from reset: one second every four cycles.
    run(3);
    check("pre_first_tick", data_ch, 24'h000000);
    run(1);
    check("first_tick", data_ch, 24'h000001);
    check("first_pulse", {23'b0, sec_pulse}, 24'h1);
    run(1);
    check("pulse_one_cycle", {23'b0, sec_pulse}, 24'h0);
    run(3);
    check("second_tick", data_ch, 24'h000002);

    // Midnight rollover.
    load_word(24'h173B3B);
    check("load_2359", data_ch, 24'h173B3B);
    check("load_no_pulse", {23'b0, sec_pulse}, 24'h0);
    run(4);
    check("midnight", data_ch, 24'h000000);
    check("midnight_wrap", {23'b0, day_wrap}, 24'h1);
    check("midnight_pulse", {23'b0, sec_pulse}, 24'h1);
    run(1);
    check("wrap_one_cycle", {23'b0, day_wrap}, 24'h0);

    // Hour carry without day wrap.
    load_word(24'h0C3B3B);
    run(4);
    check("hour_carry", data_ch, 24'h0D0000);
    check("hour_no_wrap", {23'b0, day_wrap}, 24'h0);

    // Field validation.
    load_word(24'h183C40);
    check("all_invalid", data_ch, 24'h000000);
    load_word(24'h053C10);
    check("min_invalid", data_ch, 24'h050010);

    // Load on the tick edge wins; next second a full period later.
    run(3);
    load_word(24'h010203);
    check("load_on_tick", data_ch, 24'h010203);
    check("load_on_tick_pulse", {23'b0, sec_pulse}, 24'h0);
    run(3);
    check("after_load_hold", data_ch, 24'h010203);
    run(1);
    check("after_load_tick", data_ch, 24'h010204);

    // Held load freezes time at the (sanitised) word.
    load      = 1'b1;
    load_data = 24'h123456;
    run(6);
    check("held_load", data_ch, 24'h123400);
    load = 1'b0;
    run(3);
    check("held_release_hold", data_ch, 24'h123400);
    run(1);
    check("held_release_tick", data_ch, 24'h123401);

    // Asynchronous reset mid-count.
    load_word(24'h0A141E);
    run(2);
    check("pre_reset", data_ch, 24'h0A141E);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset", data_ch, 24'h000000);
    model_reset();
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;
    run(3);
    check("post_reset_hold", data_ch, 24'h000000);
    run(1);
    check("post_reset_tick", data_ch, 24'h000001);
    run(2);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
